// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared types and constants for the MEM/WB stage
package mem_wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int TIMEOUT_DEF = 16;

  // Word accesses only: any set bit under this mask is misaligned
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - req/ack RAM bus between the MEM/WB stage and data memory
interface mem_wb_stage_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              o_ram_req;
  logic              o_ram_we;
  logic [DATA_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_din;
  logic              i_ram_ack;
  logic [DATA_W-1:0] i_ram_dout;

  modport master (
    output o_ram_req, o_ram_we, o_ram_addr, o_ram_din,
    input  i_ram_ack, i_ram_dout
  );

  modport slave (
    input  o_ram_req, o_ram_we, o_ram_addr, o_ram_din,
    output i_ram_ack, i_ram_dout
  );

endinterface

// File: rtl/mem_wb_stage_timeout_cnt.sv
// rtl/mem_wb_stage_timeout_cnt.sv - clear/enable wait counter with terminal-count flag
module mem_timeout_cnt
  import mem_wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and register-bank write-back stage
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_uc_e_read_ram,
  input  logic              i_uc_e_write_ram,
  input  logic              i_uc_e_write_br,
  input  logic [DATA_W-1:0] i_address_ram,
  input  logic [DATA_W-1:0] i_din_ram,
  input  logic [REG_AW-1:0] i_wa_br,
  output logic              o_stall,
  mem_wb_stage_if.master    ram,
  output logic              o_e_write_br,
  output logic [REG_AW-1:0] o_wa_br,
  output logic [DATA_W-1:0] o_wd_br,
  output logic              o_mem_err
);

  state_t state, state_next;

  logic              ram_req, ram_we;
  logic [DATA_W-1:0] ram_addr, ram_din;
  logic              wbr_cap;
  logic [REG_AW-1:0] wa_cap;
  logic              mem_op, aligned, tc;

  assign mem_op  = i_uc_e_read_ram | i_uc_e_write_ram;
  assign aligned = (i_address_ram[1:0] & ALIGN_MASK) == 2'b00;
  assign o_stall = (state == WAIT);

  assign ram.o_ram_req  = ram_req;
  assign ram.o_ram_we   = ram_we;
  assign ram.o_ram_addr = ram_addr;
  assign ram.o_ram_din  = ram_din;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    ((state == WAIT) && !ram.i_ram_ack),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op && aligned) state_next = WAIT;
      WAIT:    if (ram.i_ram_ack || tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous ack and terminal count completes normally: ack is tested first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      wbr_cap      <= 1'b0;
      wa_cap       <= '0;
      o_e_write_br <= 1'b0;
      o_wa_br      <= '0;
      o_wd_br      <= '0;
      o_mem_err    <= 1'b0;
    end else begin
      o_e_write_br <= 1'b0;
      o_mem_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            o_e_write_br <= i_uc_e_write_br;
            o_wa_br      <= i_wa_br;
            o_wd_br      <= i_address_ram;
          end else if (!aligned) begin
            o_mem_err <= 1'b1;
          end else begin
            ram_req  <= 1'b1;
            ram_we   <= i_uc_e_write_ram;
            ram_addr <= i_address_ram;
            ram_din  <= i_din_ram;
            wbr_cap  <= i_uc_e_write_br;
            wa_cap   <= i_wa_br;
          end
        end
        WAIT: begin
          if (ram.i_ram_ack) begin
            ram_req      <= 1'b0;
            o_e_write_br <= wbr_cap;
            o_wa_br      <= wa_cap;
            o_wd_br      <= ram_we ? ram_addr : ram.i_ram_dout;
          end else if (tc) begin
            ram_req   <= 1'b0;
            o_mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, wbr;
  logic [31:0] addr, din;
  logic [4:0]  wa;
  logic        o_stall, o_e_write_br, o_mem_err;
  logic [4:0]  o_wa_br;
  logic [31:0] o_wd_br;

  int  checks = 0;
  int  errors = 0;
  wb_t q[$];

  mem_wb_stage_if #(.DATA_W(32)) ram_bus ();

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_uc_e_read_ram  (rd),
    .i_uc_e_write_ram (wr),
    .i_uc_e_write_br  (wbr),
    .i_address_ram    (addr),
    .i_din_ram        (din),
    .i_wa_br          (wa),
    .o_stall          (o_stall),
    .ram              (ram_bus),
    .o_e_write_br     (o_e_write_br),
    .o_wa_br          (o_wa_br),
    .o_wd_br          (o_wd_br),
    .o_mem_err        (o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] x);
    rd = r; wr = w; wbr = b; addr = a; din = d; wa = x;
  endtask

  // Every BR write the DUT performs must match the next expected entry
  always @(negedge clk) begin
    wb_t e;
    if (rst_n === 1'b1 && o_e_write_br === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected observed wa=%0d wd=0x%0h expected no write", o_wa_br, o_wd_br);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wb_wa", 32'(o_wa_br), 32'(e.wa));
        chk("wb_wd", o_wd_br, e.wd);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    ram_bus.i_ram_ack  = 1'b0;
    ram_bus.i_ram_dout = '0;
    step(); step();
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_req", 32'(ram_bus.o_ram_req), 0);
    chk("rst_we", 32'(ram_bus.o_ram_we), 0);
    chk("rst_addr", ram_bus.o_ram_addr, 0);
    chk("rst_din", ram_bus.o_ram_din, 0);
    chk("rst_wbr", 32'(o_e_write_br), 0);
    chk("rst_wa", 32'(o_wa_br), 0);
    chk("rst_wd", o_wd_br, 0);
    chk("rst_err", 32'(o_mem_err), 0);
    rst_n = 1'b1;

    // ALU op: one-cycle write-back, no stall
    drive(0, 0, 1, 32'h10, 0, 5'd3);
    q.push_back('{wa: 5'd3, wd: 32'h10});
    step();
    chk("alu_stall", 32'(o_stall), 0);
    chk("alu_wbr", 32'(o_e_write_br), 1);
    chk("alu_wa", 32'(o_wa_br), 3);
    chk("alu_wd", o_wd_br, 32'h10);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("alu_wbr_pulse", 32'(o_e_write_br), 0);

    // Load acked in its third request cycle; inputs changed under stall are ignored
    drive(1, 0, 1, 32'h40, 0, 5'd7);
    q.push_back('{wa: 5'd7, wd: 32'hDEADBEEF});
    step();
    drive(0, 0, 1, 32'h99, 0, 5'd1);
    for (int k = 1; k <= 3; k++) begin
      chk("ld_req", 32'(ram_bus.o_ram_req), 1);
      chk("ld_we", 32'(ram_bus.o_ram_we), 0);
      chk("ld_stall", 32'(o_stall), 1);
      chk("ld_addr", ram_bus.o_ram_addr, 32'h40);
      if (k == 3) begin
        ram_bus.i_ram_ack  = 1'b1;
        ram_bus.i_ram_dout = 32'hDEADBEEF;
      end
      step();
    end
    ram_bus.i_ram_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("ld_req_drop", 32'(ram_bus.o_ram_req), 0);
    chk("ld_stall_drop", 32'(o_stall), 0);
    chk("ld_wbr", 32'(o_e_write_br), 1);
    chk("ld_wd", o_wd_br, 32'hDEADBEEF);
    chk("ld_wa", 32'(o_wa_br), 7);

    // Store acked after one cycle, followed back-to-back by an ALU op
    drive(0, 1, 0, 32'h20, 32'h1234, 5'd2);
    step();
    chk("st_req", 32'(ram_bus.o_ram_req), 1);
    chk("st_we", 32'(ram_bus.o_ram_we), 1);
    chk("st_addr", ram_bus.o_ram_addr, 32'h20);
    chk("st_din", ram_bus.o_ram_din, 32'h1234);
    chk("st_stall", 32'(o_stall), 1);
    ram_bus.i_ram_ack = 1'b1;
    step();
    ram_bus.i_ram_ack = 1'b0;
    chk("st_wbr", 32'(o_e_write_br), 0);
    chk("st_stall_drop", 32'(o_stall), 0);
    drive(0, 0, 1, 32'h55, 0, 5'd9);
    q.push_back('{wa: 5'd9, wd: 32'h55});
    step();
    chk("b2b_wbr", 32'(o_e_write_br), 1);
    chk("b2b_wd", o_wd_br, 32'h55);

    // Misaligned load
    drive(1, 0, 1, 32'h22, 0, 5'd5);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("mis_req", 32'(ram_bus.o_ram_req), 0);
    chk("mis_err", 32'(o_mem_err), 1);
    chk("mis_wbr", 32'(o_e_write_br), 0);
    chk("mis_stall", 32'(o_stall), 0);
    step();
    chk("mis_err_pulse", 32'(o_mem_err), 0);

    // Load that times out after 4 request cycles; late ack ignored
    drive(1, 0, 1, 32'h80, 0, 5'd4);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("to_req", 32'(ram_bus.o_ram_req), 1);
      chk("to_err_low", 32'(o_mem_err), 0);
      step();
    end
    chk("to_req_drop", 32'(ram_bus.o_ram_req), 0);
    chk("to_err", 32'(o_mem_err), 1);
    chk("to_wbr", 32'(o_e_write_br), 0);
    chk("to_stall", 32'(o_stall), 0);
    ram_bus.i_ram_ack  = 1'b1;
    ram_bus.i_ram_dout = 32'hBAD;
    step();
    ram_bus.i_ram_ack = 1'b0;
    chk("late_ack_wbr", 32'(o_e_write_br), 0);
    chk("late_ack_err", 32'(o_mem_err), 0);

    // Reset in the second wait cycle of a load
    drive(1, 0, 1, 32'h90, 0, 5'd6);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("mr_req_pre", 32'(ram_bus.o_ram_req), 1);
    rst_n = 1'b0;
    step();
    chk("mr_req", 32'(ram_bus.o_ram_req), 0);
    chk("mr_stall", 32'(o_stall), 0);
    chk("mr_addr", ram_bus.o_ram_addr, 0);
    chk("mr_wd", o_wd_br, 0);
    chk("mr_wa", 32'(o_wa_br), 0);
    rst_n = 1'b1;
    ram_bus.i_ram_ack  = 1'b1;
    ram_bus.i_ram_dout = 32'h77;
    step();
    ram_bus.i_ram_ack = 1'b0;
    chk("mr_ack_wbr", 32'(o_e_write_br), 0);
    chk("mr_ack_wd", o_wd_br, 0);
    step();
    chk("sb_drained", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access and write-back stage directly downstream of the EX/MEM pipeline register. Consumes that register's RAM enables, BR write enable, address (ALU result) and store data. Drives a variable-latency RAM over a req/ack handshake and stalls the upstream pipeline while an access is outstanding. Registers the final write-back result (RAM read data or ALU result) toward the register bank (BR).

Parameters:
DATA_W, 32, datapath and address width
REG_AW, 5, BR write-address width
TIMEOUT, 16, max cycles to wait for i_ram_ack before aborting (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
i_uc_e_read_ram  in  1  load request (from EX/MEM register)
i_uc_e_write_ram  in  1  store request
i_uc_e_write_br  in  1  BR write enable for this instruction
i_address_ram  in  DATA_W  RAM address / ALU result
i_din_ram  in  DATA_W  store data
i_wa_br  in  REG_AW  BR destination register
o_stall  out  1  hold upstream stages; combinational from state
o_ram_req  out  1  RAM request, held until ack
o_ram_we  out  1  1 = write, 0 = read; valid while o_ram_req
o_ram_addr  out  DATA_W  RAM address
o_ram_din  out  DATA_W  RAM write data
i_ram_ack  in  1  RAM completion, one-cycle pulse
i_ram_dout  in  DATA_W  read data, valid with i_ram_ack
o_e_write_br  out  1  BR write enable (registered)
o_wa_br  out  REG_AW  BR write address
o_wd_br  out  DATA_W  BR write data
o_mem_err  out  1  one-cycle pulse on a misaligned or timed-out access

Behaviour:
- Reset (rst_n=0 at the edge): state IDLE; counter 0. o_ram_req, o_ram_we, o_e_write_br and o_mem_err = 0. o_ram_addr, o_ram_din, o_wa_br and o_wd_br = 0.
- Reset asserted mid-access: o_ram_req drops at that edge. A later ack is ignored and no write-back occurs.
- States: IDLE, WAIT. o_stall = (state == WAIT).
- Inputs are sampled only in IDLE. They are ignored in WAIT because upstream is frozen.
- Non-memory op in IDLE (read = write = 0): at the next edge, o_e_write_br <= i_uc_e_write_br, o_wa_br <= i_wa_br, o_wd_br <= i_address_ram. Latency 1 cycle, no stall.
- Memory op in IDLE with i_address_ram[1:0] == 0:
  - At the next edge: state <= WAIT, o_ram_req <= 1, o_ram_we <= i_uc_e_write_ram. Address, store data, write-enable and wa are captured.
  - o_e_write_br <= 0 for this cycle.
- Read and write both asserted: treated as a write. The read is ignored; no error.
- Misaligned memory op (addr[1:0] != 0): no RAM request is issued. o_mem_err pulses 1 at the next edge and o_e_write_br <= 0. State stays IDLE.
- WAIT, ack received (i_ram_ack=1): at the edge, o_ram_req <= 0, state <= IDLE, and o_e_write_br <= captured write-enable.
  - Read: o_wd_br <= i_ram_dout.
  - Write: o_wd_br <= captured address.
  - Write-back is visible the cycle after ack. o_stall is high during the ack cycle and low the cycle after, when a new op may be accepted.
- Ack while o_ram_req = 0 is ignored.
- WAIT, no ack: the counter increments each cycle. When it reaches TIMEOUT-1 without ack, at that edge: o_ram_req <= 0, o_mem_err <= 1 for 1 cycle, o_e_write_br <= 0, state <= IDLE.
- Ack in the same cycle the counter hits TIMEOUT-1: the ack wins and the access completes normally.
- o_e_write_br and o_mem_err are single-cycle unless re-loaded by the next instruction.
- Address wrap is not handled; the address is passed unmodified.

Decomposition:
- Package mem_wb_pkg:
  - state enum {IDLE, WAIT}
  - DATA_W / REG_AW defaults
  - alignment-mask constant
  - localparam for the counter width, $clog2(TIMEOUT)
- Sub-module mem_timeout_cnt: clear/enable counter with a terminal-count flag, parameterised by TIMEOUT. The FSM and write-back register stay in the top module.

Test Plan:
1. ALU op, no memory: addr=0x0000_0010, wa=3, write_br=1. Expect o_wd_br=0x10, o_wa_br=3, o_e_write_br=1 one cycle later; o_stall never high.
2. Load, ack after 3 cycles, dout=0xDEAD_BEEF, wa=7. Expect o_ram_req high exactly 3 cycles with o_ram_we=0 and o_stall high for those 3 cycles. The next cycle has o_wd_br=0xDEADBEEF, o_wa_br=7, o_e_write_br=1.
3. Store addr=0x20, din=0x1234, ack after 1 cycle. Expect o_ram_we=1, o_ram_addr=0x20, o_ram_din=0x1234, o_e_write_br=0. A new op issued right after is accepted with no lost cycle.
4. Load at addr=0x22 (misaligned). Expect no o_ram_req, o_mem_err=1 for one cycle, o_e_write_br=0.
5. Load with TIMEOUT=4 and no ack. Expect o_ram_req to drop after 4 cycles, o_mem_err pulse, no BR write. A late ack arriving afterwards has no effect.
6. rst_n=0 in the 2nd WAIT cycle of a load. Expect all outputs 0 at the next edge. An ack the following cycle causes no write-back.
